apb_event_arbiter: RTL and testbench

Collects event pulses from several independent sources into per-source saturating pending counters. A round-robin scheduler then drains each counter as one APB write transfer to a per-source address. It sits between event-producing logic and a single APB completer and owns the only APB master port. Events are never dropped while a transfer is stalled; counts accumulate, or saturate and flag.

---
 rtl/apb_event_arbiter_pkg.sv | 29 ++
 rtl/apb_event_arbiter_if.sv | 31 +++
 rtl/apb_event_arbiter_rr_arbiter.sv | 30 +++
 rtl/apb_event_arbiter.sv | 131 +++++++++++++
 tb/tb_apb_event_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_event_arbiter_pkg.sv
// Shared types and constants for the APB event arbiter.
//   state_t  : transfer FSM states
//   EVT_ADDR : APB address written for each event source (up to 8 sources)
//   OVF_BIT  : bit of the write data that carries the saturation flag
package apb_evt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam int MAX_EVT = 8;
    localparam int OVF_BIT = 31;

    // Sources 0..2 have fixed addresses; sources 3..7 are offset from the
    // source-2 base by k * 64 KiB.
    localparam logic [31:0] EVT_ADDR [MAX_EVT] = '{
        32'hABBA_0000,
        32'hBAFF_0000,
        32'hCAFE_0000,
        32'hCAFE_0000 + 32'd3 * 32'h0001_0000,
        32'hCAFE_0000 + 32'd4 * 32'h0001_0000,
        32'hCAFE_0000 + 32'd5 * 32'h0001_0000,
        32'hCAFE_0000 + 32'd6 * 32'h0001_0000,
        32'hCAFE_0000 + 32'd7 * 32'h0001_0000
    };

endpackage

// File: rtl/apb_event_arbiter_if.sv
// APB bus between the event arbiter (master) and a single completer.
//   apb_psel_o / apb_penable_o / apb_paddr_o / apb_pwrite_o / apb_pwdata_o : master -> completer
//   apb_pready_i                                                           : completer -> master
interface apb_event_arbiter_if;

    logic        apb_psel_o;
    logic        apb_penable_o;
    logic [31:0] apb_paddr_o;
    logic        apb_pwrite_o;
    logic [31:0] apb_pwdata_o;
    logic        apb_pready_i;

    modport master (
        output apb_psel_o,
        output apb_penable_o,
        output apb_paddr_o,
        output apb_pwrite_o,
        output apb_pwdata_o,
        input  apb_pready_i
    );

    modport slave (
        input  apb_psel_o,
        input  apb_penable_o,
        input  apb_paddr_o,
        input  apb_pwrite_o,
        input  apb_pwdata_o,
        output apb_pready_i
    );

endinterface

// File: rtl/apb_event_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : one request bit per source
//   last_grant : index of the most recently granted source
//   grant      : one-hot winner, searching last_grant+1, last_grant+2, ... mod NUM_EVT
//   valid      : at least one request is present
module rr_arbiter #(
    parameter int NUM_EVT = 3,
    localparam int IDX_W  = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic [NUM_EVT-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_EVT-1:0] grant,
    output logic               valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // off = NUM_EVT wraps back to last_grant itself, so it is searched last.
        for (int off = 1; off <= NUM_EVT; off++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(last_grant) + off) % NUM_EVT);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_event_arbiter.sv
// Event-to-APB drain engine.
// Counts event pulses per source in saturating counters (with a sticky
// overflow flag) and drains each non-zero counter as one APB write to the
// source's address, choosing sources round-robin.
//   clk     : clock, rising edge
//   reset   : synchronous active-low reset
//   event_i : one pulse per cycle per source
//   apb     : APB master port (psel/penable/paddr/pwrite/pwdata out, pready in)
//   busy_o  : high while a transfer is in SETUP or ACCESS
module apb_event_arbiter
    import apb_evt_pkg::*;
#(
    parameter int NUM_EVT = 3,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_EVT-1:0]  event_i,
    apb_event_arbiter_if.master apb,
    output logic                busy_o
);

    localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   pending_reg  [NUM_EVT];
    logic [CNT_W-1:0]   pending_next [NUM_EVT];
    logic [NUM_EVT-1:0] ovf_reg, ovf_next;
    logic [NUM_EVT-1:0] req, grant;
    logic               grant_valid;
    logic               capture;
    logic [IDX_W-1:0]   last_grant_reg;
    logic [IDX_W-1:0]   win_idx;
    logic [2:0]         addr_sel;
    logic [31:0]        pwdata_cap;
    logic               psel_reg, penable_reg, busy_reg;
    logic [31:0]        paddr_reg, pwdata_reg;

    // Per-source counter update. A capture clears the counter but still
    // counts an event arriving in the same cycle, so nothing is lost.
    generate
        for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_src
            logic take;
            logic at_max;
            assign take   = capture && grant[gi];
            assign at_max = (pending_reg[gi] == CNT_MAX);
            assign req[gi] = |pending_reg[gi];
            assign pending_next[gi] = take ? CNT_W'(event_i[gi]) :
                                      (event_i[gi] && !at_max) ? pending_reg[gi] + 1'b1 :
                                      pending_reg[gi];
            assign ovf_next[gi] = take ? 1'b0 :
                                  (event_i[gi] && at_max) ? 1'b1 :
                                  ovf_reg[gi];
        end
    endgenerate

    rr_arbiter #(.NUM_EVT(NUM_EVT)) u_rr (
        .req        (req),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .valid      (grant_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (grant[k]) win_idx = IDX_W'(k);
        end
    end

    assign addr_sel = 3'(win_idx);

    always_comb begin
        pwdata_cap                = '0;
        pwdata_cap[CNT_W-1:0]     = pending_reg[win_idx];
        pwdata_cap[OVF_BIT]       = ovf_reg[win_idx];
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    capture    = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP:   state_next = ACCESS;
            ACCESS:  if (apb.apb_pready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            for (int k = 0; k < NUM_EVT; k++) pending_reg[k] <= '0;
            ovf_reg        <= '0;
            last_grant_reg <= IDX_W'(NUM_EVT - 1);
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
        end else begin
            state_reg <= state_next;
            for (int k = 0; k < NUM_EVT; k++) pending_reg[k] <= pending_next[k];
            ovf_reg     <= ovf_next;
            psel_reg    <= (state_next != IDLE);
            penable_reg <= (state_next == ACCESS);
            busy_reg    <= (state_next != IDLE);
            if (capture) begin
                paddr_reg      <= EVT_ADDR[addr_sel];
                pwdata_reg     <= pwdata_cap;
                last_grant_reg <= win_idx;
            end
        end
    end

    assign apb.apb_psel_o    = psel_reg;
    assign apb.apb_penable_o = penable_reg;
    assign apb.apb_paddr_o   = paddr_reg;
    assign apb.apb_pwrite_o  = 1'b1;
    assign apb.apb_pwdata_o  = pwdata_reg;
    assign busy_o            = busy_reg;

endmodule

// File: tb/tb_apb_event_arbiter.sv
module tb_apb_event_arbiter;

    localparam int NUM_EVT = 3;
    localparam int CNT_W   = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_EVT-1:0] event_i = '0;
    logic               busy_o;

    apb_event_arbiter_if apb ();

    apb_event_arbiter #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .event_i (event_i),
        .apb     (apb),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t obs_q[$];

    // Reference model: pending counts per source, a transfer in flight, and
    // the list of writes that should complete, in order.
    int    m_pend [NUM_EVT];
    bit    m_ovf  [NUM_EVT];
    int    m_last;
    int    m_phase;   // 0 free, 1 address phase, 2 data phase
    xfer_t m_cur;

    function automatic logic [31:0] src_addr(input int k);
        if (k == 0) return 32'hABBA_0000;
        if (k == 1) return 32'hBAFF_0000;
        if (k == 2) return 32'hCAFE_0000;
        return 32'hCAFE_0000 + 32'(k) * 32'h0001_0000;
    endfunction

    task automatic model_step();
        if (!reset) begin
            for (int k = 0; k < NUM_EVT; k++) begin
                m_pend[k] = 0;
                m_ovf[k]  = 1'b0;
            end
            m_last  = NUM_EVT - 1;
            m_phase = 0;
            return;
        end
        if (m_phase == 0) begin
            for (int off = 1; off <= NUM_EVT; off++) begin
                int w;
                w = (m_last + off) % NUM_EVT;
                if (m_pend[w] > 0) begin
                    m_cur.addr = src_addr(w);
                    m_cur.data = {m_ovf[w], 31'(m_pend[w])};
                    m_pend[w]  = 0;
                    m_ovf[w]   = 1'b0;
                    m_last     = w;
                    m_phase    = 1;
                    break;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (apb.apb_pready_i) begin
            exp_q.push_back(m_cur);
            m_phase = 0;
        end
        for (int k = 0; k < NUM_EVT; k++) begin
            if (event_i[k]) begin
                if (m_pend[k] == CMAX) m_ovf[k] = 1'b1;
                else m_pend[k]++;
            end
        end
    endtask

    // One clock: record a completing write at the falling edge, advance the
    // model on the rising edge, return 1 time unit after it.
    task automatic tick();
        @(negedge clk);
        if (apb.apb_psel_o && apb.apb_penable_o && apb.apb_pready_i)
            obs_q.push_back({apb.apb_paddr_o, apb.apb_pwdata_o});
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic bit model_active();
        if (m_phase != 0) return 1'b1;
        for (int k = 0; k < NUM_EVT; k++) if (m_pend[k] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic settle();
        int n;
        n = 0;
        apb.apb_pready_i = 1'b1;
        event_i = '0;
        while (model_active() && n < 3000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        if (n >= 3000) begin
            tests_run++;
            tests_failed++;
            $display("FAIL settle_timeout: got still active after %0d cycles, expected idle", n);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apb.apb_pready_i = 1'b1;
        event_i = '0;
        repeat (3) tick();
        tests_run += 6;
        if (apb.apb_psel_o !== 1'b0) begin tests_failed++; $display("FAIL reset_psel: got %b expected 0", apb.apb_psel_o); end
        if (apb.apb_penable_o !== 1'b0) begin tests_failed++; $display("FAIL reset_penable: got %b expected 0", apb.apb_penable_o); end
        if (apb.apb_paddr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_paddr: got %h expected 0", apb.apb_paddr_o); end
        if (apb.apb_pwdata_o !== 32'h0) begin tests_failed++; $display("FAIL reset_pwdata: got %h expected 0", apb.apb_pwdata_o); end
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        if (apb.apb_pwrite_o !== 1'b1) begin tests_failed++; $display("FAIL reset_pwrite: got %b expected 1", apb.apb_pwrite_o); end
        reset = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o); end
        obs_q.delete();
        exp_q.delete();
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        event_i = 3'b001;
        tick();                               // E0
        event_i = '0;
        tests_run++;
        if (apb.apb_psel_o !== 1'b0) begin tests_failed++; $display("FAIL single_psel_e0: got %b expected 0", apb.apb_psel_o); end
        tick();                               // E1: address phase
        tests_run += 4;
        if (apb.apb_psel_o !== 1'b1) begin tests_failed++; $display("FAIL single_psel_e1: got %b expected 1", apb.apb_psel_o); end
        if (apb.apb_penable_o !== 1'b0) begin tests_failed++; $display("FAIL single_penable_e1: got %b expected 0", apb.apb_penable_o); end
        if (apb.apb_paddr_o !== 32'hABBA_0000) begin tests_failed++; $display("FAIL single_paddr: got %h expected abba0000", apb.apb_paddr_o); end
        if (apb.apb_pwdata_o !== 32'h1) begin tests_failed++; $display("FAIL single_pwdata: got %h expected 00000001", apb.apb_pwdata_o); end
        tick();                               // E2: data phase
        tests_run += 2;
        if (apb.apb_penable_o !== 1'b1) begin tests_failed++; $display("FAIL single_penable_e2: got %b expected 1", apb.apb_penable_o); end
        if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL single_busy_e2: got %b expected 1", busy_o); end
        tick();                               // E3: back to idle
        tests_run += 3;
        if (apb.apb_psel_o !== 1'b0) begin tests_failed++; $display("FAIL single_psel_e3: got %b expected 0", apb.apb_psel_o); end
        if (apb.apb_penable_o !== 1'b0) begin tests_failed++; $display("FAIL single_penable_e3: got %b expected 0", apb.apb_penable_o); end
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL single_busy_e3: got %b expected 0", busy_o); end
        settle();
        tests_run++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL single_count: got %0d transfers expected %0d (model) and 1", obs_q.size(), exp_q.size());
        end else if (obs_q[0] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL single_xfer: got %h expected %h", obs_q[0], exp_q[0]);
        end
        obs_q.delete();
        exp_q.delete();
        $display("[TB] test_single done");
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        for (int burst = 0; burst < 2; burst++) begin
            event_i = 3'b111;
            tick();
            event_i = '0;
            settle();
            tests_run++;
            if (obs_q.size() != 3 || exp_q.size() != 3) begin
                tests_failed++;
                $display("FAIL simul_count%0d: got %0d transfers (model %0d) expected 3", burst, obs_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    tests_run += 2;
                    if (obs_q[i].addr !== src_addr(i) || obs_q[i].data !== 32'h1) begin
                        tests_failed++;
                        $display("FAIL simul_order%0d_%0d: got %h/%h expected %h/00000001", burst, i, obs_q[i].addr, obs_q[i].data, src_addr(i));
                    end
                    if (obs_q[i] !== exp_q[i]) begin
                        tests_failed++;
                        $display("FAIL simul_model%0d_%0d: got %h expected %h", burst, i, obs_q[i], exp_q[i]);
                    end
                end
            end
            obs_q.delete();
            exp_q.delete();
        end
        $display("[TB] test_simultaneous done");
    endtask

    task automatic test_fairness();
        int n0, i1;
        event_i = 3'b001;
        repeat (6) tick();
        n0 = obs_q.size();
        event_i = 3'b011;
        tick();
        event_i = 3'b001;
        repeat (30) tick();
        settle();
        i1 = -1;
        for (int i = n0; i < obs_q.size(); i++) begin
            if (obs_q[i].addr == 32'hBAFF_0000 && i1 < 0) i1 = i;
        end
        tests_run++;
        if (i1 < 0 || (i1 - n0) > 1) begin
            tests_failed++;
            $display("FAIL fair_grant: got source-1 at position %0d after pulse, expected at most 1", (i1 < 0) ? -1 : i1 - n0);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL fair_count: got %0d transfers expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (obs_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL fair_xfer%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
        $display("[TB] test_fairness done");
    endtask

    task automatic test_collision();
        event_i = 3'b010;
        tick();                              // E0: count 1
        tick();                              // E1: capture with an event in the same cycle
        event_i = '0;
        tests_run++;
        if (apb.apb_pwdata_o !== 32'h1) begin tests_failed++; $display("FAIL collide_first: got %h expected 00000001", apb.apb_pwdata_o); end
        settle();
        tests_run++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            tests_failed++;
            $display("FAIL collide_count: got %0d transfers (model %0d) expected 2", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (obs_q[i] !== {32'hBAFF_0000, 32'h1} || obs_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL collide_xfer%0d: got %h expected %h", i, obs_q[i], {32'hBAFF_0000, 32'h1});
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
        $display("[TB] test_collision done");
    endtask

    task automatic test_stall();
        apb.apb_pready_i = 1'b0;
        event_i = 3'b100;
        repeat (300) tick();
        event_i = '0;
        repeat (4) tick();
        settle();
        event_i = 3'b100;
        tick();
        event_i = '0;
        settle();
        tests_run++;
        if (obs_q.size() != 3) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d transfers expected 3", obs_q.size());
        end else begin
            tests_run += 3;
            if (obs_q[0].data !== 32'h1) begin tests_failed++; $display("FAIL stall_first: got %h expected 00000001", obs_q[0].data); end
            if (obs_q[1].data !== 32'h8000_00FF || obs_q[1].addr !== 32'hCAFE_0000) begin
                tests_failed++;
                $display("FAIL stall_sat: got %h/%h expected cafe0000/800000ff", obs_q[1].addr, obs_q[1].data);
            end
            if (obs_q[2].data !== 32'h1) begin tests_failed++; $display("FAIL stall_ovf_clear: got %h expected 00000001", obs_q[2].data); end
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL stall_model_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (obs_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL stall_xfer%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
        $display("[TB] test_stall done");
    endtask

    task automatic test_reset_mid();
        apb.apb_pready_i = 1'b0;
        event_i = 3'b010;
        tick();
        event_i = '0;
        tick();
        tick();
        event_i = 3'b010;
        repeat (5) tick();
        event_i = '0;
        tests_run++;
        if (apb.apb_penable_o !== 1'b1) begin tests_failed++; $display("FAIL rmid_in_access: got penable %b expected 1", apb.apb_penable_o); end
        reset = 1'b0;
        tick();
        tests_run += 5;
        if (apb.apb_psel_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_psel: got %b expected 0", apb.apb_psel_o); end
        if (apb.apb_penable_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_penable: got %b expected 0", apb.apb_penable_o); end
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %b expected 0", busy_o); end
        if (apb.apb_paddr_o !== 32'h0) begin tests_failed++; $display("FAIL rmid_paddr: got %h expected 0", apb.apb_paddr_o); end
        if (apb.apb_pwdata_o !== 32'h0) begin tests_failed++; $display("FAIL rmid_pwdata: got %h expected 0", apb.apb_pwdata_o); end
        reset = 1'b1;
        apb.apb_pready_i = 1'b1;
        repeat (20) tick();
        tests_run += 2;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL rmid_no_xfer: got %0d transfers expected 0", obs_q.size()); end
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_idle: got busy %b expected 0", busy_o); end
        obs_q.delete();
        exp_q.delete();
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            event_i = NUM_EVT'($urandom) & NUM_EVT'($urandom);
            apb.apb_pready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        settle();
        tests_run++;
        if (obs_q.size() != exp_q.size() || obs_q.size() == 0) begin
            tests_failed++;
            $display("FAIL random_count: got %0d transfers expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (obs_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL random_xfer%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
        $display("[TB] test_random done");
    endtask

    initial begin
        apb.apb_pready_i = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_collision();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
